zoom_rep_addr_gen: RTL and testbench

ZOOM_REP_ADDR_GEN -- requirements
Module: zoom_rep_addr_gen

---
 rtl/zoom_pkg.sv | 31 +++
 rtl/zoom_coord_map.sv | 37 +++
 rtl/zoom_rep_addr_gen.sv | 182 ++++++++++++++++++
 tb/tb_zoom_rep_addr_gen.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/zoom_pkg.sv
// zoom_pkg -- shared definitions for the zoom/replicate address generator.
//   * zoom factor encodings carried on fator_zoom
//   * FSM state encoding (also visible on the estado_dbg port of the top)
//   * shift_of(): factor code -> right-shift applied to destination coords
package zoom_pkg;

  // Zoom factor codes
  localparam logic [1:0] FATOR_1X = 2'b00;
  localparam logic [1:0] FATOR_2X = 2'b01;
  localparam logic [1:0] FATOR_4X = 2'b10;
  localparam logic [1:0] FATOR_8X = 2'b11;

  // FSM states; OCIOSO is all-zero so a reset state reads as 0 on the debug port
  localparam logic [1:0] ST_OCIOSO   = 2'b00;
  localparam logic [1:0] ST_VARRENDO = 2'b01;
  localparam logic [1:0] ST_FIM      = 2'b10;

  // Each destination pixel is replicated 2^shift times per axis.
  function automatic logic [1:0] shift_of(input logic [1:0] fator);
    logic [1:0] s;
    case (fator)
      FATOR_1X: s = 2'd0;
      FATOR_2X: s = 2'd1;
      FATOR_4X: s = 2'd2;
      FATOR_8X: s = 2'd3;
      default:  s = 2'd0;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/zoom_coord_map.sv
// zoom_coord_map -- combinational per-axis mapping from a destination
// coordinate to a source coordinate:
//   fonte = min(offset + (destino >> shift), LIMITE)
// The sum is formed one bit wider than the coordinate so a large offset
// saturates at LIMITE instead of wrapping.
// Ports:
//   destino_i  destination coordinate
//   shift_i    replication shift (0..3)
//   offset_i   pan origin in source coordinates
//   fonte_o    clamped source coordinate
module zoom_coord_map #(
  parameter int COORD_W = 10,
  parameter int LIMITE  = 159
) (
  input  logic [COORD_W-1:0] destino_i,
  input  logic [1:0]         shift_i,
  input  logic [COORD_W-1:0] offset_i,
  output logic [COORD_W-1:0] fonte_o
);

  localparam int SUM_W = COORD_W + 1;
  localparam logic [SUM_W-1:0] LIM = SUM_W'(LIMITE);

  logic [COORD_W-1:0] escalado;
  logic [SUM_W-1:0]   soma;

  always_comb begin
    escalado = destino_i >> shift_i;
    soma     = {1'b0, offset_i} + {1'b0, escalado};
    if (soma > LIM) begin
      fonte_o = LIM[COORD_W-1:0];
    end else begin
      fonte_o = soma[COORD_W-1:0];
    end
  end

endmodule

// File: rtl/zoom_rep_addr_gen.sv
// zoom_rep_addr_gen -- scans a LARG_DEST x ALT_DEST destination frame in
// raster order and, for each destination pixel, emits the source pixel of a
// LARG_FONTE x ALT_FONTE image after integer zoom (pixel replication) and pan.
//
// Handshake: a tuple is transferred on every rising edge where
// valido_saida & pronto_saida are both high. valido_saida never drops while a
// tuple is pending, and every output holds stable until the transfer happens.
//
// Ports:
//   clk, reset          rising-edge clock, synchronous active-high reset
//   start               one-cycle frame request (honoured only when idle)
//   fator_zoom          00=1x 01=2x 10=4x 11=8x (latched on start)
//   offset_x/offset_y   pan origin in source coords (latched on start)
//   pronto_saida        downstream ready
//   valido_saida        output tuple valid
//   x_destino/y_destino current destination pixel
//   x_fonte/y_fonte     mapped source pixel
//   endereco_fonte      y_fonte*LARG_FONTE + x_fonte
//   ultimo              marks the final pixel of the frame
//   ocupado             frame scan in progress
//   fim_quadro          one-cycle pulse after the last pixel is taken
//   estado_dbg          current FSM state
module zoom_rep_addr_gen
  import zoom_pkg::*;
#(
  parameter int LARG_DEST  = 640,
  parameter int ALT_DEST   = 480,
  parameter int LARG_FONTE = 160,
  parameter int ALT_FONTE  = 120,
  parameter int COORD_W    = 10,
  localparam int ADDR_W    = $clog2(LARG_FONTE * ALT_FONTE)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [1:0]         fator_zoom,
  input  logic [COORD_W-1:0] offset_x,
  input  logic [COORD_W-1:0] offset_y,
  input  logic               pronto_saida,
  output logic               valido_saida,
  output logic [COORD_W-1:0] x_destino,
  output logic [COORD_W-1:0] y_destino,
  output logic [COORD_W-1:0] x_fonte,
  output logic [COORD_W-1:0] y_fonte,
  output logic [ADDR_W-1:0]  endereco_fonte,
  output logic               ultimo,
  output logic               ocupado,
  output logic               fim_quadro,
  output logic [1:0]         estado_dbg
);

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(LARG_DEST - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(ALT_DEST - 1);

  logic [1:0]         estado_q, estado_d;
  logic [1:0]         fator_q, fator_d;
  logic [COORD_W-1:0] off_x_q, off_x_d;
  logic [COORD_W-1:0] off_y_q, off_y_d;
  logic [COORD_W-1:0] xd_q, xd_d;
  logic [COORD_W-1:0] yd_q, yd_d;
  logic [COORD_W-1:0] xf_q, xf_d;
  logic [COORD_W-1:0] yf_q, yf_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic               carrega;
  logic               na_ultima;
  logic [1:0]         shift_d;

  assign na_ultima = (xd_q == X_MAX) && (yd_q == Y_MAX);

  // Next-state / next-tuple selection. carrega marks cycles where a new
  // tuple is loaded into the output registers (start or a non-final beat).
  always_comb begin
    estado_d = estado_q;
    fator_d  = fator_q;
    off_x_d  = off_x_q;
    off_y_d  = off_y_q;
    xd_d     = xd_q;
    yd_d     = yd_q;
    carrega  = 1'b0;
    case (estado_q)
      ST_OCIOSO: begin
        if (start) begin
          estado_d = ST_VARRENDO;
          fator_d  = fator_zoom;
          off_x_d  = offset_x;
          off_y_d  = offset_y;
          xd_d     = '0;
          yd_d     = '0;
          carrega  = 1'b1;
        end
      end
      ST_VARRENDO: begin
        if (pronto_saida) begin
          if (na_ultima) begin
            estado_d = ST_FIM;
          end else begin
            carrega = 1'b1;
            if (xd_q == X_MAX) begin
              xd_d = '0;
              yd_d = yd_q + 1'b1;
            end else begin
              xd_d = xd_q + 1'b1;
            end
          end
        end
      end
      ST_FIM: begin
        estado_d = ST_OCIOSO;
      end
      default: begin
        estado_d = ST_OCIOSO;
      end
    endcase
  end

  // The mapping works on the *next* coordinates and the *next* latched
  // configuration, so source coords and address register on the same edge
  // as the destination coords (zero extra latency).
  assign shift_d = shift_of(fator_d);

  zoom_coord_map #(
    .COORD_W (COORD_W),
    .LIMITE  (LARG_FONTE - 1)
  ) u_map_x (
    .destino_i (xd_d),
    .shift_i   (shift_d),
    .offset_i  (off_x_d),
    .fonte_o   (xf_d)
  );

  zoom_coord_map #(
    .COORD_W (COORD_W),
    .LIMITE  (ALT_FONTE - 1)
  ) u_map_y (
    .destino_i (yd_d),
    .shift_i   (shift_d),
    .offset_i  (off_y_d),
    .fonte_o   (yf_d)
  );

  // Clamped coords keep the product inside the source image, so ADDR_W
  // arithmetic cannot overflow.
  assign addr_d = ADDR_W'(yf_d) * ADDR_W'(LARG_FONTE) + ADDR_W'(xf_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      estado_q <= ST_OCIOSO;
      fator_q  <= '0;
      off_x_q  <= '0;
      off_y_q  <= '0;
      xd_q     <= '0;
      yd_q     <= '0;
      xf_q     <= '0;
      yf_q     <= '0;
      addr_q   <= '0;
    end else begin
      estado_q <= estado_d;
      fator_q  <= fator_d;
      off_x_q  <= off_x_d;
      off_y_q  <= off_y_d;
      if (carrega) begin
        xd_q   <= xd_d;
        yd_q   <= yd_d;
        xf_q   <= xf_d;
        yf_q   <= yf_d;
        addr_q <= addr_d;
      end
    end
  end

  assign valido_saida   = (estado_q == ST_VARRENDO);
  assign ocupado        = (estado_q == ST_VARRENDO);
  assign fim_quadro     = (estado_q == ST_FIM);
  assign ultimo         = (estado_q == ST_VARRENDO) && na_ultima;
  assign x_destino      = xd_q;
  assign y_destino      = yd_q;
  assign x_fonte        = xf_q;
  assign y_fonte        = yf_q;
  assign endereco_fonte = addr_q;
  assign estado_dbg     = estado_q;

endmodule

// File: tb/tb_zoom_rep_addr_gen.sv
module tb_zoom_rep_addr_gen;

  localparam int LD = 8;
  localparam int AD = 4;
  localparam int LF = 4;
  localparam int AF = 2;
  localparam int CW = 10;
  localparam int AW = 3;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    fator;
  logic [CW-1:0] offx, offy;
  logic          pronto;
  logic          valido_saida;
  logic [CW-1:0] x_destino, y_destino, x_fonte, y_fonte;
  logic [AW-1:0] endereco_fonte;
  logic          ultimo, ocupado, fim_quadro;
  logic [1:0]    estado_dbg;

  always #5 clk = ~clk;

  zoom_rep_addr_gen #(
    .LARG_DEST  (LD),
    .ALT_DEST   (AD),
    .LARG_FONTE (LF),
    .ALT_FONTE  (AF),
    .COORD_W    (CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .fator_zoom     (fator),
    .offset_x       (offx),
    .offset_y       (offy),
    .pronto_saida   (pronto),
    .valido_saida   (valido_saida),
    .x_destino      (x_destino),
    .y_destino      (y_destino),
    .x_fonte        (x_fonte),
    .y_fonte        (y_fonte),
    .endereco_fonte (endereco_fonte),
    .ultimo         (ultimo),
    .ocupado        (ocupado),
    .fim_quadro     (fim_quadro),
    .estado_dbg     (estado_dbg)
  );

  logic [48:0] all_outs;
  assign all_outs = {valido_saida, x_destino, y_destino, x_fonte, y_fonte,
                     endereco_fonte, ultimo, ocupado, fim_quadro, estado_dbg};

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [43:0] exp_q[$];

  function automatic logic [43:0] exp_tuple(input int x, input int y, input logic [1:0] f,
                                            input int ox, input int oy);
    int s, xf, yf, addr;
    logic ult;
    case (f)
      2'b00:   s = 0;
      2'b01:   s = 1;
      2'b10:   s = 2;
      default: s = 3;
    endcase
    xf = ox + (x >> s);
    if (xf > LF - 1) xf = LF - 1;
    yf = oy + (y >> s);
    if (yf > AF - 1) yf = AF - 1;
    addr = yf * LF + xf;
    ult  = (x == LD - 1) && (y == AD - 1);
    return {ult, CW'(x), CW'(y), CW'(xf), CW'(yf), AW'(addr)};
  endfunction

  task automatic push_frame(input logic [1:0] f, input int ox, input int oy);
    for (int y = 0; y < AD; y++)
      for (int x = 0; x < LD; x++)
        exp_q.push_back(exp_tuple(x, y, f, ox, oy));
  endtask

  int          acc_cnt = 0;
  int          stall_cnt = 0;
  logic [22:0] cap_53 = '1;
  logic [CW-1:0] cap_x7 = '1;
  logic [CW-1:0] cap_x5 = '1;
  logic [43:0] act, prev_act;
  logic [43:0] exp_v;
  logic        prev_stall = 1'b0;
  logic        pending_fim = 1'b0;
  logic        has_exp;

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge clk) begin
    act = {ultimo, x_destino, y_destino, x_fonte, y_fonte, endereco_fonte};
    if (reset) begin
      prev_stall  = 1'b0;
      pending_fim = 1'b0;
    end else begin
      if (pending_fim) begin
        check_eq("fim_pulse", {61'd0, fim_quadro, valido_saida, ocupado}, 64'h4);
        pending_fim = 1'b0;
      end
      if (valido_saida) begin
        if (x_destino == 5 && y_destino == 3) cap_53 = {x_fonte, y_fonte, endereco_fonte};
        if (x_destino == 7) cap_x7 = x_fonte;
        if (x_destino == 5) cap_x5 = x_fonte;
        if (prev_stall) check_eq("hold", act, prev_act);
        if (pronto) begin
          acc_cnt++;
          has_exp = (exp_q.size() != 0);
          check_eq("exp_avail", has_exp, 1);
          if (has_exp) begin
            exp_v = exp_q.pop_front();
            check_eq("tuple", act, exp_v);
          end
          if (ultimo) pending_fim = 1'b1;
          prev_stall = 1'b0;
        end else begin
          stall_cnt++;
          prev_stall = 1'b1;
        end
        prev_act = act;
      end else begin
        prev_stall = 1'b0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Called just after a rising edge; start is sampled on the next edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Returns on the falling edge of the fim_quadro cycle.
  task automatic wait_fim(input int maxc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < maxc && !seen; i++) begin
      @(negedge clk);
      if (fim_quadro) seen = 1'b1;
    end
    check_eq("fim_seen", seen, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    bit fim_b;
    reset = 1'b1; start = 1'b0; pronto = 1'b1;
    fator = 2'b00; offx = '0; offy = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check_eq("reset_outs", all_outs, 0);

    // Frame A: 2x, no offset, always ready
    @(posedge clk); #1;
    acc_cnt = 0; stall_cnt = 0; cap_53 = '1;
    fator = 2'b01; offx = 0; offy = 0;
    push_frame(2'b01, 0, 0);
    pulse_start();
    @(negedge clk);
    check_eq("valid_after_start", {valido_saida, x_destino, y_destino}, {1'b1, 10'd0, 10'd0});
    wait_fim(100);
    check_eq("beats_a", acc_cnt, 32);
    check_eq("map_5_3", cap_53, {10'd2, 10'd1, 3'd6});
    check_eq("queue_a", exp_q.size(), 0);

    // Frame B: 8x, offset_x=3, random backpressure, mid-frame start + config change
    @(posedge clk); #1;
    acc_cnt = 0; cap_x7 = '1;
    fator = 2'b11; offx = 3; offy = 0;
    push_frame(2'b11, 3, 0);
    pulse_start();
    fim_b = 1'b0;
    for (int i = 0; i < 400 && !fim_b; i++) begin
      pronto = ($urandom_range(0, 3) != 0);
      if (i == 10) begin
        fator = 2'b00; offx = 0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (fim_quadro) fim_b = 1'b1;
    end
    start = 1'b0;
    check_eq("fim_b_seen", fim_b, 1);
    check_eq("beats_b", acc_cnt, 32);
    check_eq("map_x7_8x", cap_x7, 3);
    check_eq("queue_b", exp_q.size(), 0);

    // Frame C: started in the cycle after fim_quadro; 1x, offset_x=2; stall at (2,0)
    @(posedge clk); #1;
    acc_cnt = 0; stall_cnt = 0; cap_x5 = '1;
    pronto = 1'b1; fator = 2'b00; offx = 2; offy = 0;
    push_frame(2'b00, 2, 0);
    pulse_start();
    @(posedge clk);
    @(posedge clk); #1;
    pronto = 1'b0;
    repeat (3) @(posedge clk);
    #1 pronto = 1'b1;
    wait_fim(100);
    check_eq("stall_cnt_c", stall_cnt, 3);
    check_eq("beats_c", acc_cnt, 32);
    check_eq("map_x5_clamp", cap_x5, 3);
    check_eq("queue_c", exp_q.size(), 0);

    // Frame D: reset at beat 10
    @(posedge clk); #1;
    acc_cnt = 0;
    fator = 2'b01; offx = 0; offy = 0;
    push_frame(2'b01, 0, 0);
    pulse_start();
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_eq("reset_mid", all_outs, 0);
    check_eq("beats_before_reset", acc_cnt, 9);
    exp_q.delete();
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("no_resume", all_outs, 0);

    // Frame E: restart from origin after reset
    @(posedge clk); #1;
    acc_cnt = 0;
    push_frame(2'b01, 0, 0);
    pulse_start();
    @(negedge clk);
    check_eq("restart_origin", {valido_saida, x_destino, y_destino}, {1'b1, 10'd0, 10'd0});
    wait_fim(100);
    check_eq("beats_e", acc_cnt, 32);
    check_eq("queue_e", exp_q.size(), 0);

    // Reset wins over a simultaneous start
    @(posedge clk); #1;
    reset = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    @(negedge clk);
    check_eq("reset_prio", {valido_saida, ocupado, estado_dbg}, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
